axis_word_packer: RTL

- Sits directly downstream of the Conv2D3x3 master AXI4-Stream output. Consumes one WORD_WIDTH convolution result per handshake.
- Packs PACK consecutive results into one wide AXI4-Stream beat for the DMA write path.
- Generates TLAST and TKEEP from a programmed per-frame word count. Pulses a done flag when the last beat of the frame is accepted.

---
 rtl/axis_word_packer.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/axis_word_packer.sv
// axis_word_packer: gathers PACK consecutive WORD_WIDTH stream words into one
// wide AXI4-Stream beat. The frame length comes from a programmed word count,
// which drives TLAST/TKEEP on the final (possibly partial) beat.
module axis_word_packer #(
  parameter int WORD_WIDTH  = 8,
  parameter int PACK        = 4,
  parameter int COUNT_WIDTH = 32
) (
  input  logic                       i_aclk,
  input  logic                       i_aresetn,
  input  logic                       i_load_param,
  input  logic [COUNT_WIDTH-1:0]     i_total_words,
  input  logic                       i_s_tvalid,
  output logic                       o_s_tready,
  input  logic [WORD_WIDTH-1:0]      i_s_tdata,
  output logic                       o_m_tvalid,
  input  logic                       i_m_tready,
  output logic [WORD_WIDTH*PACK-1:0] o_m_tdata,
  output logic [PACK-1:0]            o_m_tkeep,
  output logic                       o_m_tlast,
  output logic                       o_busy,
  output logic                       o_done
);

  localparam int                     LANE_W    = $clog2(PACK);
  localparam int                     BEAT_W    = WORD_WIDTH * PACK;
  localparam logic [LANE_W-1:0]      LAST_LANE = LANE_W'(PACK - 1);
  localparam logic [LANE_W-1:0]      LANE_ONE  = LANE_W'(1);
  localparam logic [COUNT_WIDTH-1:0] CNT_ONE   = COUNT_WIDTH'(1);
  localparam logic [PACK-1:0]        ALL_ONES  = {PACK{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t                   state_q, state_d;
  logic [COUNT_WIDTH-1:0]   remaining_q, remaining_d;
  logic [LANE_W-1:0]        lane_q, lane_d;
  logic [BEAT_W-1:0]        acc_q, acc_d;
  logic                     m_tvalid_q, m_tvalid_d;
  logic [BEAT_W-1:0]        m_tdata_q, m_tdata_d;
  logic [PACK-1:0]          m_tkeep_q, m_tkeep_d;
  logic                     m_tlast_q, m_tlast_d;
  logic                     done_q, done_d;

  logic                     final_word;
  logic                     completing;
  logic                     s_tready;
  logic                     s_accept;
  logic                     m_handshake;
  logic [BEAT_W-1:0]        acc_wr;
  logic [BEAT_W-1:0]        beat_data;
  logic [PACK-1:0]          beat_keep;

  // The current word closes a beat either when it fills the top lane or when
  // it is the last word of the frame.
  assign final_word  = (remaining_q == CNT_ONE);
  assign completing  = (lane_q == LAST_LANE) || final_word;
  // A completing word needs the output register free (or draining this cycle).
  assign s_tready    = (state_q == ST_RUN) && (!completing || !m_tvalid_q || i_m_tready);
  assign s_accept    = s_tready && i_s_tvalid;
  assign m_handshake = m_tvalid_q && i_m_tready;

  // Lanes 0..lane_q are occupied once the current word is included.
  assign beat_keep = ~(ALL_ONES << (32'(lane_q) + 32'd1));

  // Per-lane steering: the current word lands in lane_q; lanes past it are zero.
  for (genvar gi = 0; gi < PACK; gi++) begin : g_lane
    localparam logic [LANE_W-1:0] LANE_IDX = LANE_W'(gi);
    assign acc_wr[gi*WORD_WIDTH +: WORD_WIDTH] =
      (LANE_IDX == lane_q) ? i_s_tdata : acc_q[gi*WORD_WIDTH +: WORD_WIDTH];
    assign beat_data[gi*WORD_WIDTH +: WORD_WIDTH] =
      (LANE_IDX == lane_q) ? i_s_tdata :
      (beat_keep[gi] ? acc_q[gi*WORD_WIDTH +: WORD_WIDTH] : {WORD_WIDTH{1'b0}});
  end

  // Next-state for frame control, accumulator and the output beat register.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    lane_d      = lane_q;
    acc_d       = acc_q;
    m_tvalid_d  = m_tvalid_q;
    m_tdata_d   = m_tdata_q;
    m_tkeep_d   = m_tkeep_q;
    m_tlast_d   = m_tlast_q;
    done_d      = 1'b0;

    // A taken beat frees the register unless a new beat loads below.
    if (m_handshake) begin
      m_tvalid_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (i_load_param) begin
          if (i_total_words != '0) begin
            state_d     = ST_RUN;
            remaining_d = i_total_words;
            lane_d      = '0;
            acc_d       = '0;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (s_accept) begin
          remaining_d = remaining_q - CNT_ONE;
          if (completing) begin
            lane_d     = '0;
            acc_d      = '0;
            m_tvalid_d = 1'b1;
            m_tdata_d  = beat_data;
            m_tkeep_d  = beat_keep;
            m_tlast_d  = final_word;
            if (final_word) begin
              state_d = ST_DRAIN;
            end
          end else begin
            lane_d = lane_q + LANE_ONE;
            acc_d  = acc_wr;
          end
        end
      end
      ST_DRAIN: begin
        if (m_handshake && m_tlast_q) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset discards any partial or pending beat.
  always_ff @(posedge i_aclk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
      lane_q      <= '0;
      acc_q       <= '0;
      m_tvalid_q  <= 1'b0;
      m_tdata_q   <= '0;
      m_tkeep_q   <= '0;
      m_tlast_q   <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      lane_q      <= lane_d;
      acc_q       <= acc_d;
      m_tvalid_q  <= m_tvalid_d;
      m_tdata_q   <= m_tdata_d;
      m_tkeep_q   <= m_tkeep_d;
      m_tlast_q   <= m_tlast_d;
      done_q      <= done_d;
    end
  end

  assign o_s_tready = s_tready;
  assign o_m_tvalid = m_tvalid_q;
  assign o_m_tdata  = m_tdata_q;
  assign o_m_tkeep  = m_tkeep_q;
  assign o_m_tlast  = m_tlast_q;
  assign o_busy     = (state_q != ST_IDLE);
  assign o_done     = done_q;

endmodule
